mu_ram_1rw_arb: RTL and testbench



---
 rtl/mu_ram_1rw_arb.sv | 240 ++++++++++++++++++++++++
 tb/tb_mu_ram_1rw_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_ram_1rw_arb.sv
// ----------------------------------------------------------------------------
// mu_ram_1rw_arb
//
// Two-requester arbiter/sequencer in front of a single-port RAM (mu_ram_1rw,
// one-cycle registered read). Typical use: port 0 = sensor frame writer,
// port 1 = display reader. At most one access is granted per cycle. Ties in
// IDLE are resolved round-robin; a port may hold ownership for a burst with
// its lock input, limited to MAX_BURST consecutive grants while the other
// port is waiting. Read data is routed back with a per-port rvalid strobe.
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins ties in IDLE and
//                          the round-robin pointer is not built. The burst
//                          limit still applies to both owners.
//
// Parameters:
//   DW         data width (equal to RAM data width)
//   AW         address width (equal to RAM address width)
//   MAX_BURST  max consecutive grants to a locked owner while the other
//              port waits (>= 1)
//
// Ports:
//   clk            clock
//   rst_n          asynchronous reset, active low
//   pN_req_i       access request, held until pN_gnt_o (N = 0,1)
//   pN_we_i        1 = write, 0 = read
//   pN_lock_i      keep ownership for the following cycles (burst)
//   pN_addr_i      access address
//   pN_wdata_i     write data
//   pN_gnt_o       access accepted this cycle (combinational)
//   pN_rvalid_o    read data valid, one cycle after a granted read
//   pN_rdata_o     read data (ram_rd_i routed)
//   ram_addr_o     RAM address
//   ram_wr_o       RAM write data
//   ram_we_o       RAM write enable
//   ram_rd_i       RAM read data
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; requests are arbitrated (single req wins, tie by rr)
// OWN0  | port 0 holds the lock; granted whenever it requests
// OWN1  | port 1 holds the lock; granted whenever it requests
// ----------------------------------------------------------------------------
module mu_ram_1rw_arb #(
  parameter int DW        = 8,
  parameter int AW        = 12,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          p0_req_i,
  input  logic          p0_we_i,
  input  logic          p0_lock_i,
  input  logic [AW-1:0] p0_addr_i,
  input  logic [DW-1:0] p0_wdata_i,
  output logic          p0_gnt_o,
  output logic          p0_rvalid_o,
  output logic [DW-1:0] p0_rdata_o,

  input  logic          p1_req_i,
  input  logic          p1_we_i,
  input  logic          p1_lock_i,
  input  logic [AW-1:0] p1_addr_i,
  input  logic [DW-1:0] p1_wdata_i,
  output logic          p1_gnt_o,
  output logic          p1_rvalid_o,
  output logic [DW-1:0] p1_rdata_o,

  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wr_o,
  output logic          ram_we_o,
  input  logic [DW-1:0] ram_rd_i
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]    rvalid_q, rvalid_d;

  logic gnt0;
  logic gnt1;
  logic tie_port;
  logic arb_free;
  logic at_max;

  // --------------------------------------------------------------------------
  // Tie-break port for IDLE arbitration
  // --------------------------------------------------------------------------
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign tie_port = 1'b0;
`else
  // rr_q holds the port that wins the next tie, i.e. the port that was NOT
  // granted last. Resetting it to 0 lets port 0 win the first tie.
  logic rr_q, rr_d;

  assign tie_port = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign at_max = (burst_cnt_q == BURST_MAX);

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == BURST_MAX) ? c : c + BURST_ONE;
  endfunction

  // --------------------------------------------------------------------------
  // Grant decision and next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    arb_free    = 1'b0;

    unique case (state_q)
      OWN0: begin
        if (p0_req_i) begin
          if (at_max && p1_req_i) begin
            // Burst limit reached with port 1 waiting: hand this cycle over.
            gnt1        = 1'b1;
            state_d     = IDLE;
            burst_cnt_d = '0;
          end else begin
            gnt0        = 1'b1;
            burst_cnt_d = cnt_inc(burst_cnt_q);
            if (!p0_lock_i) begin
              state_d     = IDLE;
              burst_cnt_d = '0;
            end
          end
        end else begin
          // Owner went quiet: release and arbitrate the other port now.
          arb_free = 1'b1;
        end
      end

      OWN1: begin
        if (p1_req_i) begin
          if (at_max && p0_req_i) begin
            gnt0        = 1'b1;
            state_d     = IDLE;
            burst_cnt_d = '0;
          end else begin
            gnt1        = 1'b1;
            burst_cnt_d = cnt_inc(burst_cnt_q);
            if (!p1_lock_i) begin
              state_d     = IDLE;
              burst_cnt_d = '0;
            end
          end
        end else begin
          arb_free = 1'b1;
        end
      end

      default: begin
        arb_free = 1'b1;
      end
    endcase

    if (arb_free) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
      if (p0_req_i && (!p1_req_i || !tie_port)) begin
        gnt0 = 1'b1;
        if (p0_lock_i) begin
          state_d     = OWN0;
          burst_cnt_d = BURST_ONE;
        end
      end else if (p1_req_i) begin
        gnt1 = 1'b1;
        if (p1_lock_i) begin
          state_d     = OWN1;
          burst_cnt_d = BURST_ONE;
        end
      end
    end
  end

  // A granted read produces rvalid on the granted port in the next cycle.
  assign rvalid_d = {gnt1 & ~p1_we_i, gnt0 & ~p0_we_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rvalid_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Grants are combinational from the requests, so they are masked with
  // rst_n to keep the RAM quiet while reset is held.
  assign p0_gnt_o = gnt0 & rst_n;
  assign p1_gnt_o = gnt1 & rst_n;

  assign ram_we_o   = rst_n & ((gnt0 & p0_we_i) | (gnt1 & p1_we_i));
  // With no grant the address follows port 0, which is a harmless read.
  assign ram_addr_o = gnt1 ? p1_addr_i  : p0_addr_i;
  assign ram_wr_o   = gnt1 ? p1_wdata_i : p0_wdata_i;

  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = ram_rd_i;
  assign p1_rdata_o  = ram_rd_i;

endmodule

// File: tb/tb_mu_ram_1rw_arb.sv
// ----------------------------------------------------------------------------
// tb_mu_ram_1rw_arb
//
// Directed bench for mu_ram_1rw_arb (MAX_BURST = 4) with a behavioural
// single-port RAM attached. Inputs change on the falling edge; outputs are
// sampled 1 ns later, so gnt/ram_* reflect the current cycle and rvalid
// reflects the grant of the previous cycle.
// ----------------------------------------------------------------------------
module tb_mu_ram_1rw_arb;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int MB = 4;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_we, p0_lock;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req, p1_we, p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr;
  logic          ram_we;
  logic [DW-1:0] ram_rd;

  int checks   = 0;
  int failures = 0;

  mu_ram_1rw_arb #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_req_i   (p0_req),
    .p0_we_i    (p0_we),
    .p0_lock_i  (p0_lock),
    .p0_addr_i  (p0_addr),
    .p0_wdata_i (p0_wdata),
    .p0_gnt_o   (p0_gnt),
    .p0_rvalid_o(p0_rvalid),
    .p0_rdata_o (p0_rdata),
    .p1_req_i   (p1_req),
    .p1_we_i    (p1_we),
    .p1_lock_i  (p1_lock),
    .p1_addr_i  (p1_addr),
    .p1_wdata_i (p1_wdata),
    .p1_gnt_o   (p1_gnt),
    .p1_rvalid_o(p1_rvalid),
    .p1_rdata_o (p1_rdata),
    .ram_addr_o (ram_addr),
    .ram_wr_o   (ram_wr),
    .ram_we_o   (ram_we),
    .ram_rd_i   (ram_rd)
  );

  // Behavioural single-port RAM: registered read, read register holds on write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;
  assign ram_rd = rd_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wr;
    else        rd_q <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          r0, w0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          eg0, eg1, ewe;
    logic [AW-1:0] eaddr;
    logic          erv0, erv1;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(input int r0, input int w0, input int l0,
                              input int a0, input int d0,
                              input int r1, input int w1, input int l1,
                              input int a1, input int d1,
                              input int eg0, input int eg1, input int ewe,
                              input int eaddr, input int erv0, input int erv1,
                              input int erd);
    vec_t v;
    v.r0 = r0[0]; v.w0 = w0[0]; v.l0 = l0[0];
    v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = r1[0]; v.w1 = w1[0]; v.l1 = l1[0];
    v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.eg0 = eg0[0]; v.eg1 = eg1[0]; v.ewe = ewe[0];
    v.eaddr = AW'(eaddr);
    v.erv0 = erv0[0]; v.erv1 = erv1[0];
    v.erd = DW'(erd);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic eg0, input logic eg1,
                             input logic ewe, input logic [AW-1:0] eaddr,
                             input logic erv0, input logic erv1,
                             input logic [DW-1:0] erd);
    chk({tag, ".p0_gnt"},    32'(p0_gnt),    32'(eg0));
    chk({tag, ".p1_gnt"},    32'(p1_gnt),    32'(eg1));
    chk({tag, ".ram_we"},    32'(ram_we),    32'(ewe));
    chk({tag, ".ram_addr"},  32'(ram_addr),  32'(eaddr));
    chk({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'(erv0));
    chk({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'(erv1));
    if (erv0) chk({tag, ".p0_rdata"}, 32'(p0_rdata), 32'(erd));
    if (erv1) chk({tag, ".p1_rdata"}, 32'(p1_rdata), 32'(erd));
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    p0_req = r0; p0_we = w0; p0_lock = l0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_lock = l1; p1_addr = a1; p1_wdata = d1;
  endtask

  logic          ep;
  logic          pend0, pend1;
  logic [DW-1:0] pend_d;

  initial begin
    // T1/T2 and single-port / lock-release sequences, MAX_BURST = 4
    vt[0]  = mk(1,1,0,'h010,'hA5, 0,0,0,'h000,'h00, 1,0,1,'h010,0,0,'h00);
    vt[1]  = mk(0,0,0,'h010,'h00, 1,0,0,'h010,'h00, 0,1,0,'h010,0,0,'h00);
    vt[2]  = mk(0,0,0,'h3FF,'h00, 0,0,0,'h010,'h00, 0,0,0,'h3FF,0,1,'hA5);
    vt[3]  = mk(0,0,0,'h3FF,'h00, 1,1,0,'h020,'h5A, 0,1,1,'h020,0,0,'h00);
    vt[4]  = mk(1,0,0,'h020,'h00, 1,1,0,'h030,'hC3, 1,0,0,'h020,0,0,'h00);
    vt[5]  = mk(0,0,0,'h020,'h00, 1,1,0,'h030,'hC3, 0,1,1,'h030,1,0,'h5A);
    vt[6]  = mk(1,0,0,'h030,'h00, 0,0,0,'h030,'h00, 1,0,0,'h030,0,0,'h00);
    vt[7]  = mk(0,0,0,'h000,'h00, 0,0,0,'h000,'h00, 0,0,0,'h000,1,0,'hC3);
    vt[8]  = mk(1,1,1,'h040,'h11, 0,0,0,'h000,'h00, 1,0,1,'h040,0,0,'h00);
    vt[9]  = mk(0,1,1,'h040,'h11, 1,0,0,'h040,'h00, 0,1,0,'h040,0,0,'h00);
    vt[10] = mk(0,0,0,'h001,'h00, 0,0,0,'h040,'h00, 0,0,0,'h001,0,1,'h11);
    vt[11] = mk(0,0,0,'h001,'h00, 1,1,1,'h050,'h22, 0,1,1,'h050,0,0,'h00);
    vt[12] = mk(1,0,0,'h050,'h00, 1,1,1,'h051,'h33, 0,1,1,'h051,0,0,'h00);
    vt[13] = mk(1,0,0,'h050,'h00, 1,1,0,'h052,'h44, 0,1,1,'h052,0,0,'h00);
    vt[14] = mk(1,0,0,'h050,'h00, 0,0,0,'h052,'h00, 1,0,0,'h050,0,0,'h00);
    vt[15] = mk(0,0,0,'h000,'h00, 0,0,0,'h000,'h00, 0,0,0,'h000,1,0,'h22);

    // Reset held with both ports requesting writes: nothing may be granted.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1, 1'b1, 1'b0, 12'h456, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check_cycle("rst", 1'b0, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0, 8'h00);

    // Table vectors; reset is released on the first falling edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(vt[i].r0, vt[i].w0, vt[i].l0, vt[i].a0, vt[i].d0,
            vt[i].r1, vt[i].w1, vt[i].l1, vt[i].a1, vt[i].d1);
      #1;
      check_cycle($sformatf("vec%0d", i), vt[i].eg0, vt[i].eg1, vt[i].ewe,
                  vt[i].eaddr, vt[i].erv0, vt[i].erv1, vt[i].erd);
    end

    // T5: reset asserted in the cycle of a granted read.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 12'h040, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    #1;
    chk("t5.read_gnt", 32'(p0_gnt), 32'd1);
    #1;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 12'h040, 8'h00, 1'b1, 1'b1, 1'b1, 12'h041, 8'h00);
    #1;
    chk("t5.gnt_async", 32'(p0_gnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_cycle($sformatf("t5.rst%0d", i), 1'b0, 1'b0, 1'b0, 12'h040,
                  1'b0, 1'b0, 8'h00);
    end

    // T3: both read continuously, no lock, starting right after reset.
    pend0 = 1'b0; pend1 = 1'b0; pend_d = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 12'h050, 8'h00, 1'b1, 1'b0, 1'b0, 12'h040, 8'h00);
      #1;
      ep = FIXED ? 1'b0 : 1'(k % 2);
      check_cycle($sformatf("t3.c%0d", k), ~ep, ep, 1'b0,
                  ep ? 12'h040 : 12'h050, pend0, pend1, pend_d);
      pend0  = ~ep;
      pend1  = ep;
      pend_d = ep ? 8'h11 : 8'h22;
    end

    // T4: p0 locked write burst with p1 read waiting; lock dropped after.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, (k < 5), AW'(12'h100 + k), DW'(8'h80 + k),
            1'b1, 1'b0, 1'b0, 12'h100, 8'h00);
      #1;
      if (k < 4)       ep = 1'b0;
      else if (k == 4) ep = 1'b1;
      else             ep = FIXED ? 1'b0 : 1'((k - 5) % 2);
      check_cycle($sformatf("t4.c%0d", k), ~ep, ep, ~ep,
                  ep ? 12'h100 : AW'(12'h100 + k), pend0, pend1, pend_d);
      pend0  = 1'b0;
      pend1  = ep;
      pend_d = 8'h80;
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
    #1;
    check_cycle("t4.tail", 1'b0, 1'b0, 1'b0, 12'h000, pend0, pend1, pend_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
